// File: rtl/demux_1ton_reg_if.sv
// Bus bundle for demux_1ton_reg.
// The master drives en/in/sel. The slave (the demux) returns the
// combinational fan-out, the registered copy and the range flag.
interface demux_1ton_reg_if #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
);
  logic             en;
  logic             in;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     out;
  logic [N-1:0]     out_q;
  logic             sel_err;

  modport master (
    output en, in, sel,
    input  out, out_q, sel_err
  );

  modport slave (
    input  en, in, sel,
    output out, out_q, sel_err
  );
endinterface

// File: rtl/demux_1ton_reg.sv
// 1-to-N single-bit demultiplexer.
// The combinational path routes `in` onto the lane selected by `sel`, and
// every other lane reads 0. An enable-gated register stage holds a copy of
// that result, together with a flag that marks an out-of-range select
// (sel >= N). That flag can only be set when N is not a power of two.
// Legal N is 2..256.

// One decoder lane: it passes `in` through only when sel addresses this lane.
module demux_1ton_lane #(
  parameter int SEL_W = 3,
  parameter int LANE  = 0
) (
  input  logic             in,
  input  logic [SEL_W-1:0] sel,
  output logic             o
);
  localparam logic [SEL_W-1:0] LANE_IDX = SEL_W'(LANE);

  // An X on sel gives an X here in simulation, so unknown selects stay visible.
  assign o = in & (sel == LANE_IDX);
endmodule

module demux_1ton_reg #(
  parameter  int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1ton_reg_if.slave    bus
);
  // Lane indices past N-1 exist only when N is not a power of two.
  localparam bit               IS_POW2 = (N == (1 << SEL_W));
  localparam logic [SEL_W:0]   N_EXT   = (SEL_W + 1)'(N);

  logic [N-1:0] out_c;
  logic         sel_oor;

  logic [N-1:0] out_q_d, out_q_q;
  logic         sel_err_d, sel_err_q;

  // Decoder: one lane instance per output bit.
  for (genvar k = 0; k < N; k++) begin : g_lane
    demux_1ton_lane #(
      .SEL_W (SEL_W),
      .LANE  (k)
    ) u_lane (
      .in  (bus.in),
      .sel (bus.sel),
      .o   (out_c[k])
    );
  end

  assign bus.out = out_c;

  // Unsigned range compare. It is widened by one bit so that N == 2**SEL_W fits.
  assign sel_oor = IS_POW2 ? 1'b0 : ({1'b0, bus.sel} >= N_EXT);

  // Next state of the register stage: capture when enabled, otherwise hold.
  always_comb begin
    out_q_d   = out_q_q;
    sel_err_d = sel_err_q;
    if (bus.en) begin
      out_q_d   = out_c;
      sel_err_d = sel_oor;
    end
  end

  // Register stage. A synchronous reset takes priority over en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      out_q_q   <= out_q_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.out_q   = out_q_q;
  assign bus.sel_err = sel_err_q;

  // A capturing edge must never see an unknown select.
  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
    bus.en |-> !$isunknown(bus.sel));
endmodule

// File: tb/tb_demux_1ton_reg.sv
// Directed and scoreboard-checked bench for demux_1ton_reg.
// It runs one instance with N=8 (power of two) and one with N=6 (non power of two).
module tb_demux_1ton_reg;
  logic clk = 1'b0;
  logic rst_n8, rst_n6;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  demux_1ton_reg_if #(.N(8)) if8 ();
  demux_1ton_reg_if #(.N(6)) if6 ();

  demux_1ton_reg #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n8), .bus(if8));
  demux_1ton_reg #(.N(6)) u_dut6 (.clk(clk), .rst_n(rst_n6), .bus(if6));

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       in;
    logic [2:0] sel;
    logic [7:0] exp_out;
    logic [7:0] exp_q;
    logic       exp_err;
  } vec_t;

  vec_t vt [9];

  // Reference demux: the bit goes to the selected lane, and nothing is driven when sel is out of range.
  function automatic logic [7:0] dmx(int n, logic b, logic [2:0] s);
    logic [7:0] r;
    r = 8'h00;
    if (int'(s) < n) r = 8'(b) << s;
    return r;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_prev;
    logic [7:0] held_q8, held_q6;
    logic       held_e6;
    logic [7:0] mq8, mq6;
    logic       me6;

    vt[0] = '{1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 8'h00, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 8'h08, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 8'h08, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 8'h80, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 8'h00, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 8'h00, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h01, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 8'h00, 1'b0};

    rst_n8 = 1'b0; rst_n6 = 1'b0;
    if8.en = 1'b0; if8.in = 1'b0; if8.sel = '0;
    if6.en = 1'b0; if6.in = 1'b0; if6.sel = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_q8",   if8.out_q,          8'h00);
    chk("rst_err8", 8'(if8.sel_err),    8'h00);
    chk("rst_q6",   {2'b00, if6.out_q}, 8'h00);
    chk("rst_err6", 8'(if6.sel_err),    8'h00);

    // Exhaustive combinational sweep, N=8
    rst_n8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      if8.sel = iv[2:0];
      if8.in  = iv[3];
      #1;
      chk($sformatf("sweep_out[%0d]", i), if8.out, 8'(iv[3]) << iv[2:0]);
    end

    // Table-driven registered path, N=8
    exp_prev = 8'h00;
    for (int i = 0; i < 9; i++) begin
      rst_n8  = vt[i].rst_n;
      if8.en  = vt[i].en;
      if8.in  = vt[i].in;
      if8.sel = vt[i].sel;
      #1;
      chk($sformatf("vec%0d_out", i),    if8.out,   vt[i].exp_out);
      chk($sformatf("vec%0d_q_pre", i),  if8.out_q, exp_prev);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_q", i),      if8.out_q, vt[i].exp_q);
      chk($sformatf("vec%0d_err", i),    8'(if8.sel_err), 8'(vt[i].exp_err));
      exp_prev = vt[i].exp_q;
    end

    // Non-power-of-two, N=6: out-of-range select
    rst_n6 = 1'b1; if6.en = 1'b1; if6.in = 1'b1; if6.sel = 3'd7;
    #1;
    chk("n6_oor_out", {2'b00, if6.out}, 8'h00);
    @(posedge clk); #1;
    chk("n6_oor_err", 8'(if6.sel_err),    8'h01);
    chk("n6_oor_q",   {2'b00, if6.out_q}, 8'h00);
    if6.sel = 3'd2;
    #1;
    chk("n6_sel2_out", {2'b00, if6.out}, 8'h04);
    @(posedge clk); #1;
    chk("n6_sel2_err", 8'(if6.sel_err),    8'h00);
    chk("n6_sel2_q",   {2'b00, if6.out_q}, 8'h04);
    if6.sel = 3'd6;
    @(posedge clk); #1;
    chk("n6_sel6_err", 8'(if6.sel_err),    8'h01);
    chk("n6_sel6_q",   {2'b00, if6.out_q}, 8'h00);
    if6.en = 1'b0; if6.sel = 3'd1;
    @(posedge clk); #1;
    chk("n6_hold_err", 8'(if6.sel_err),    8'h01);
    chk("n6_hold_out", {2'b00, if6.out},   8'h02);

    // Enable hold with changing inputs (N=8 holds data, N=6 holds the error flag)
    rst_n8 = 1'b1; if8.en = 1'b1; if8.in = 1'b1; if8.sel = 3'd4;
    @(posedge clk); #1;
    chk("hold_load_q8", if8.out_q, 8'h10);
    held_q8 = 8'h10; held_q6 = 8'h00; held_e6 = 1'b1;
    if8.en = 1'b0; if6.en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if8.sel = 3'($urandom_range(0, 7)); if8.in = 1'($urandom_range(0, 1));
      if6.sel = 3'($urandom_range(0, 7)); if6.in = 1'($urandom_range(0, 1));
      #1;
      chk("hold_out8", if8.out,          dmx(8, if8.in, if8.sel));
      chk("hold_out6", {2'b00, if6.out}, dmx(6, if6.in, if6.sel));
      @(posedge clk); #1;
      chk("hold_q8",   if8.out_q,          held_q8);
      chk("hold_err8", 8'(if8.sel_err),    8'h00);
      chk("hold_q6",   {2'b00, if6.out_q}, held_q6);
      chk("hold_err6", 8'(if6.sel_err),    8'(held_e6));
    end

    // Randomised run against the scoreboard model
    mq8 = if8.out_q; mq6 = {2'b00, if6.out_q}; me6 = if6.sel_err;
    for (int c = 0; c < 1000; c++) begin
      rst_n8 = ($urandom_range(0, 9) != 0);
      rst_n6 = ($urandom_range(0, 9) != 0);
      if8.en = 1'($urandom_range(0, 1)); if6.en = 1'($urandom_range(0, 1));
      if8.in = 1'($urandom_range(0, 1)); if6.in = 1'($urandom_range(0, 1));
      if8.sel = 3'($urandom_range(0, 7)); if6.sel = 3'($urandom_range(0, 7));
      #1;
      chk("rnd_out8", if8.out,          dmx(8, if8.in, if8.sel));
      chk("rnd_out6", {2'b00, if6.out}, dmx(6, if6.in, if6.sel));
      chk("rnd_1hot8", 8'($countones(if8.out) <= 1), 8'h01);
      chk("rnd_1hot6", 8'($countones(if6.out) <= 1), 8'h01);
      if (!rst_n8)     mq8 = 8'h00;
      else if (if8.en) mq8 = dmx(8, if8.in, if8.sel);
      if (!rst_n6) begin
        mq6 = 8'h00; me6 = 1'b0;
      end else if (if6.en) begin
        mq6 = dmx(6, if6.in, if6.sel); me6 = (if6.sel >= 3'd6);
      end
      @(posedge clk); #1;
      chk("rnd_q8",   if8.out_q,          mq8);
      chk("rnd_err8", 8'(if8.sel_err),    8'h00);
      chk("rnd_q6",   {2'b00, if6.out_q}, mq6);
      chk("rnd_err6", 8'(if6.sel_err),    8'(me6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux_1ton_reg.md
Name: demux_1toN_reg

Overview:
- Parameterised 1-to-N single-bit demultiplexer: routes the scalar input `in` to exactly one of N output bits selected by `sel`. All other output bits are driven 0.
- Provides a zero-latency combinational output for datapath fan-out and a registered, enable-gated copy for timing-critical consumers.
- Flags out-of-range selects when N is not a power of two.
- Sits between a serial control/data source and per-lane consumers, e.g. lane enables or strobe distribution.

Parameters:
- N, default 8, number of output lanes; legal range 2..256.
- SEL_W, default $clog2(N), select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  registered-path update enable
- in  input  1  data bit to route
- sel  input  SEL_W  lane index
- out  output  N  combinational demux result
- out_q  output  N  registered demux result
- sel_err  output  1  registered flag: last enabled sel was out of range

Behaviour:
- Combinational path, no clock involvement:
  - out[k] = in when sel == k, else 0, for every k in 0..N-1.
  - out is at most one-hot and equals all-zero when in == 0.
  - out settles in the same delta/cycle as in and sel changes; no latch inferred.
- Out-of-range select (sel >= N, only possible when N is not a power of two):
  - out = all zeros.
- Registered path, on rising clk:
  - rst_n == 0 (synchronous, dominates en): out_q <= 0, sel_err <= 0.
  - else if en == 1: out_q <= out (same-cycle combinational value); sel_err <= (sel >= N).
  - else (en == 0): out_q and sel_err hold their previous values.
- Latency:
  - out: 0 cycles.
  - out_q and sel_err: 1 cycle after the enabled sampling edge.
- Reset mid-operation: the next clock edge with rst_n low forces out_q = 0 and sel_err = 0 regardless of en, in or sel. The combinational out is unaffected by reset.
- Reset release: the first edge with rst_n high and en high captures normally.
- Simultaneous in/sel change with en high: capture reflects the values present at the edge. No glitch filtering is required.
- Width rules:
  - sel is compared as unsigned.
  - When N is a power of two, sel_err is constant 0 after reset.
- No X propagation by design:
  - X on sel drives all out bits X in simulation only.
  - Assertions require sel to be known whenever en == 1.
- Implementation: a decoder loop or generate per lane, plus the register stage and the range compare.

Test Plan:
- Exhaustive combinational sweep, N=8: for i in 0..15, sel = i[2:0], in = i[3].
  - Required: out == (in << sel), e.g. sel=5, in=1 -> out=8'b0010_0000; in=0 -> out=8'h00 for all sel.
- Registered latency: rst_n=1, en=1, sel=3, in=1 at edge t.
  - Required: out_q=8'h08 after t.
  - Then en=0, sel=6 at edge t+1: out_q stays 8'h08 while out=8'h40.
- Synchronous reset: with out_q=8'h80, drive rst_n=0 and en=1 for one edge.
  - Required: out_q=8'h00 and sel_err=0 after that edge, not before; out still tracks in/sel combinationally.
- Non-power-of-two, N=6: sel=7, in=1, en=1.
  - Required: out=6'b000000 immediately; sel_err=1 and out_q=0 after the edge.
  - Then sel=2: sel_err=0 and out_q=6'b000100 after the next edge.
- Enable hold with changing inputs: en=0 for 10 cycles with random sel/in.
  - Required: out_q and sel_err unchanged; out matches the reference model every cycle.
- Randomised 1000 cycles with random rst_n/en: the scoreboard model must match out_q, sel_err and out each cycle, with out at most one-hot.
